// File: rtl/bank_rw_mode_fsm_pkg.sv
// Shared bank-scheduler definitions: read/write FSM state encoding, direction
// constants and default timing parameters for the read/write mode arbiter.
package bank_rw_mode_fsm_pkg;

    typedef enum logic [1:0] {
        RD_MODE = 2'd0,
        RD2WR   = 2'd1,
        WR_MODE = 2'd2,
        WR2RD   = 2'd3
    } rw_mode_state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int TURN_CYC_DEF   = 4;
    localparam int MIN_BURST_DEF  = 4;
    localparam int STARVE_MAX_DEF = 32;

endpackage

// File: rtl/bank_rw_mode_fsm_sat_counter.sv
// Clearable up-counter with an at-max flag; the caller holds it at MAX by
// gating inc with sat. clr wins over inc.
module bank_sat_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == W'(MAX));

endmodule

// File: rtl/bank_rw_mode_fsm.sv
// Read/write direction arbiter for one bank: watermark- and starvation-driven
// switching with a fixed bus-turnaround gap and a minimum burst per mode.
module bank_rw_mode_fsm
    import bank_rw_mode_fsm_pkg::*;
#(
    parameter int TURN_CYC   = TURN_CYC_DEF,
    parameter int MIN_BURST  = MIN_BURST_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lwm,
    input  logic       hwm,
    input  logic       rd_pending,
    input  logic       wr_pending,
    input  logic       grant_o,
    output logic       mode,
    output logic       issue_en,
    output logic       switch_pulse,
    output logic [1:0] state_o
);

    localparam int BW = $clog2(MIN_BURST + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    rw_mode_state_t state, next_state;

    logic [BW-1:0] burst_cnt;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] turn_cnt;
    logic          burst_sat, starve_sat, turn_sat;
    logic          in_mode, burst_full, starve_full, turn_done;
    logic          rd_to_wr, wr_to_rd;
    logic          burst_inc, burst_clr, starve_inc, starve_clr, turn_inc, turn_clr;

    assign in_mode     = (state == RD_MODE) || (state == WR_MODE);
    assign burst_full  = (burst_cnt == BW'(MIN_BURST));
    assign starve_full = (starve_cnt == SW'(STARVE_MAX));
    assign turn_done   = (turn_cnt == TW'(TURN_CYC - 1));

    // Starvation bypasses the minimum-burst gate; all causes fold into one switch.
    assign rd_to_wr = (hwm && burst_full) || starve_full || (!rd_pending && wr_pending);
    assign wr_to_rd = (lwm && rd_pending && burst_full) || (!wr_pending && rd_pending);

    // Grants during turnaround are protocol errors and are not counted.
    assign burst_inc  = in_mode && grant_o && !burst_sat;
    assign burst_clr  = in_mode && (next_state != state);
    assign starve_inc = (state == RD_MODE) && wr_pending && !starve_sat;
    assign starve_clr = (state == RD2WR) && (next_state == WR_MODE);
    assign turn_inc   = !in_mode && !turn_sat;
    assign turn_clr   = !in_mode && turn_done;

    bank_sat_counter #(.MAX(MIN_BURST), .W(BW)) u_burst (
        .clk(clk), .rst_n(rst_n), .inc(burst_inc), .clr(burst_clr),
        .count(burst_cnt), .sat(burst_sat)
    );

    bank_sat_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve (
        .clk(clk), .rst_n(rst_n), .inc(starve_inc), .clr(starve_clr),
        .count(starve_cnt), .sat(starve_sat)
    );

    bank_sat_counter #(.MAX(TURN_CYC), .W(TW)) u_turn (
        .clk(clk), .rst_n(rst_n), .inc(turn_inc), .clr(turn_clr),
        .count(turn_cnt), .sat(turn_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RD_MODE;
            switch_pulse <= 1'b0;
        end else begin
            state        <= next_state;
            switch_pulse <= burst_clr;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RD_MODE: if (rd_to_wr)  next_state = RD2WR;
            RD2WR:   if (turn_done) next_state = WR_MODE;
            WR_MODE: if (wr_to_rd)  next_state = WR2RD;
            WR2RD:   if (turn_done) next_state = RD_MODE;
            default:                next_state = RD_MODE;
        endcase
    end

    // Turnaround states already present the target direction on mode.
    always_comb begin
        mode     = READ;
        issue_en = 1'b1;
        case (state)
            RD2WR: begin
                mode     = WRITE;
                issue_en = 1'b0;
            end
            WR_MODE: mode = WRITE;
            WR2RD:   issue_en = 1'b0;
            default: ;
        endcase
        state_o = state;
    end

endmodule

// File: tb/tb_bank_rw_mode_fsm.sv
// Directed bench for bank_rw_mode_fsm: per-cycle expected outputs are queued by
// the driver and checked by an independent monitor after each rising edge.
module tb_bank_rw_mode_fsm;
    import bank_rw_mode_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lwm = 1'b0, hwm = 1'b0, rd_pending = 1'b0, wr_pending = 1'b0, grant_o = 1'b0;
    logic       mode, issue_en, switch_pulse;
    logic [1:0] state_o;

    logic [4:0] exp_q[$];
    string      tag_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    logic [4:0] mon_exp, mon_act;
    string      mon_tag;

    always #5 clk = ~clk;

    bank_rw_mode_fsm dut (
        .clk(clk), .rst_n(rst_n), .lwm(lwm), .hwm(hwm),
        .rd_pending(rd_pending), .wr_pending(wr_pending), .grant_o(grant_o),
        .mode(mode), .issue_en(issue_en), .switch_pulse(switch_pulse), .state_o(state_o)
    );

    // Expected {state, mode, issue_en, switch_pulse} from the state table.
    function automatic logic [4:0] pack_exp(input rw_mode_state_t st, input logic pulse);
        logic m, ie;
        m  = (st == RD_MODE || st == WR2RD) ? READ : WRITE;
        ie = (st == RD_MODE || st == WR_MODE);
        return {st, m, ie, pulse};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string tag, input logic r, input logic rd, input logic wr,
                        input logic h, input logic l, input logic g,
                        input rw_mode_state_t st, input logic p);
        @(negedge clk);
        rst_n = r; rd_pending = rd; wr_pending = wr; hwm = h; lwm = l; grant_o = g;
        exp_q.push_back(pack_exp(st, p));
        tag_q.push_back(tag);
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {state_o, mode, issue_en, switch_pulse};
            n_tests++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: {state,mode,issue_en,pulse} got %b want %b",
                         mon_tag, mon_act, mon_exp);
            end
        end
    end

    initial begin
        // reset
        repeat (2) step("reset", 0, 0, 0, 0, 0, 0, RD_MODE, 0);
        after_edge();
        check_cnt("reset_burst_cnt", int'(dut.burst_cnt), 0);
        check_cnt("reset_starve_cnt", int'(dut.starve_cnt), 0);

        // hwm switch after four reads, then write-mode watermark behaviour
        repeat (4) step("rd_grants", 1, 1, 0, 0, 0, 1, RD_MODE, 0);
        step("hwm_switch", 1, 1, 1, 1, 0, 0, RD2WR, 1);
        repeat (3) step("rd2wr_hold", 1, 1, 1, 0, 0, 0, RD2WR, 0);
        step("enter_wr", 1, 1, 1, 0, 0, 0, WR_MODE, 0);
        after_edge();
        check_cnt("wr_entry_starve_cnt", int'(dut.starve_cnt), 0);
        check_cnt("wr_entry_burst_cnt", int'(dut.burst_cnt), 0);
        repeat (4) step("wr_grants", 1, 0, 1, 0, 0, 1, WR_MODE, 0);
        repeat (2) step("lwm_no_reads", 1, 0, 1, 0, 1, 0, WR_MODE, 0);
        step("lwm_switch", 1, 1, 1, 0, 1, 0, WR2RD, 1);
        repeat (3) step("wr2rd_hold", 1, 1, 1, 0, 0, 0, WR2RD, 0);
        step("enter_rd", 1, 1, 0, 0, 0, 0, RD_MODE, 0);
        after_edge();
        check_cnt("rd_entry_burst_cnt", int'(dut.burst_cnt), 0);

        // hwm before MIN_BURST grants is held off until the burst completes
        repeat (2) step("gate_grants", 1, 1, 0, 0, 0, 1, RD_MODE, 0);
        repeat (2) step("gate_hwm", 1, 1, 0, 1, 0, 1, RD_MODE, 0);
        step("gate_switch", 1, 1, 0, 1, 0, 0, RD2WR, 1);
        repeat (3) step("turn_grant_ignored", 1, 1, 0, 0, 0, 1, RD2WR, 0);
        step("enter_wr_2", 1, 1, 0, 0, 0, 1, WR_MODE, 0);
        after_edge();
        check_cnt("turn_grants_not_counted", int'(dut.burst_cnt), 0);
        step("wr_empty_switch", 1, 1, 0, 0, 0, 0, WR2RD, 1);
        repeat (3) step("wr2rd_hold_2", 1, 1, 0, 0, 0, 0, WR2RD, 0);
        step("enter_rd_2", 1, 1, 0, 0, 0, 0, RD_MODE, 0);

        // write starvation forces a switch on the 33rd cycle of pending writes
        for (int i = 0; i < 32; i++) step("starve_fill", 1, 1, 1, 0, 0, 1, RD_MODE, 0);
        after_edge();
        check_cnt("starve_cnt_full", int'(dut.starve_cnt), 32);
        step("starve_switch", 1, 1, 1, 0, 0, 1, RD2WR, 1);
        repeat (3) step("rd2wr_hold_3", 1, 1, 1, 0, 0, 0, RD2WR, 0);
        step("enter_wr_3", 1, 1, 1, 0, 0, 0, WR_MODE, 0);
        after_edge();
        check_cnt("starve_cleared_in_wr", int'(dut.starve_cnt), 0);

        // write-mode holds, empty-queue switches, idle read mode
        step("wr_only_writes", 1, 0, 1, 0, 0, 0, WR_MODE, 0);
        step("wr_idle", 1, 0, 0, 0, 0, 0, WR_MODE, 0);
        step("lwm_burst_gate", 1, 1, 1, 0, 1, 0, WR_MODE, 0);
        step("wr_empty_switch_2", 1, 1, 0, 0, 0, 0, WR2RD, 1);
        repeat (3) step("wr2rd_hold_4", 1, 0, 0, 0, 0, 0, WR2RD, 0);
        step("enter_rd_3", 1, 0, 0, 0, 0, 0, RD_MODE, 0);
        repeat (2) step("rd_idle", 1, 0, 0, 0, 0, 0, RD_MODE, 0);
        step("rd_empty_switch", 1, 0, 1, 0, 0, 0, RD2WR, 1);

        // reset in the second turnaround cycle with a stray grant
        step("rd2wr_cycle2", 1, 0, 1, 0, 0, 1, RD2WR, 0);
        step("reset_mid_turn", 0, 0, 1, 0, 0, 1, RD_MODE, 0);
        after_edge();
        check_cnt("mid_turn_reset_burst_cnt", int'(dut.burst_cnt), 0);
        check_cnt("mid_turn_reset_starve_cnt", int'(dut.starve_cnt), 0);
        step("post_reset", 1, 1, 0, 0, 0, 0, RD_MODE, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
